fifo_cmd_dispatch: RTL and testbench

//  Read-side consumer of the 57-bit dual-clock command FIFO. Runs entirely in the FIFO read-clock domain.

---
 rtl/fifo_cmd_dispatch.sv | 152 +++++++++++++++
 tb/tb_fifo_cmd_dispatch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_cmd_dispatch.sv
// fifo_cmd_dispatch
// Read-side consumer of the dual-clock command FIFO. Pops one 57-bit word,
// decodes it as {rnw, addr, data}, and issues it as a single register-bus
// read or write. It then waits for reg_ack or a timeout. Read results are
// returned on rsp_data with a one-cycle rsp_valid pulse. Everything runs in
// the FIFO read-clock domain.

module fifo_cmd_dispatch #(
  parameter int unsigned DW      = 57,
  parameter int unsigned AW      = 24,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [DW-1:0] fifo_q,
  input  logic          fifo_rdempty,
  output logic          fifo_rdreq,
  output logic [AW-1:0] reg_addr,
  output logic [31:0]   reg_wdata,
  output logic          reg_we,
  output logic          reg_re,
  input  logic          reg_ack,
  input  logic [31:0]   reg_rdata,
  output logic [31:0]   rsp_data,
  output logic          rsp_valid,
  output logic [CW-1:0] timeout_cnt,
  output logic          busy
);

  // The wait counter only has to reach TIMEOUT-1. The final ACCESS cycle
  // is the one in which the counter holds that value.
  localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  // Field positions inside a FIFO word: {rnw, addr, data}.
  localparam int unsigned RNW_BIT = DW - 1;
  localparam int unsigned ADDR_LO = 32;

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_pop    = 2'd1,
    st_latch  = 2'd2,
    st_access = 2'd3
  } state_t;

  state_t        state_r;
  logic          rnw_r;
  logic [WW-1:0] wait_r;

  // Dispatch FSM: pop, latch, one bus access, then back to idle. All
  // outputs are registered here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= st_idle;
      rnw_r       <= 1'b0;
      wait_r      <= {WW{1'b0}};
      fifo_rdreq  <= 1'b0;
      reg_addr    <= {AW{1'b0}};
      reg_wdata   <= 32'h0000_0000;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      rsp_data    <= 32'h0000_0000;
      rsp_valid   <= 1'b0;
      timeout_cnt <= {CW{1'b0}};
      busy        <= 1'b0;
    end else begin
      // Single-cycle pulses fall back to 0 unless a state re-asserts them.
      fifo_rdreq <= 1'b0;
      rsp_valid  <= 1'b0;

      case (state_r)
        st_idle: begin
          // enable is only looked at here. An access in flight always
          // runs to completion.
          if (enable && !fifo_rdempty) begin
            fifo_rdreq <= 1'b1;
            busy       <= 1'b1;
            state_r    <= st_pop;
          end else begin
            busy       <= 1'b0;
            state_r    <= st_idle;
          end
        end

        st_pop: begin
          // The FIFO is in normal (non show-ahead) mode. fifo_q becomes
          // valid in the cycle after the rdreq pulse.
          busy    <= 1'b1;
          state_r <= st_latch;
        end

        st_latch: begin
          rnw_r     <= fifo_q[RNW_BIT];
          reg_addr  <= fifo_q[RNW_BIT-1:ADDR_LO];
          reg_wdata <= fifo_q[31:0];
          // Exactly one strobe is raised, selected by the rnw bit.
          reg_re    <= fifo_q[RNW_BIT];
          reg_we    <= ~fifo_q[RNW_BIT];
          wait_r    <= {WW{1'b0}};
          busy      <= 1'b1;
          state_r   <= st_access;
        end

        st_access: begin
          if (reg_ack) begin
            // An ack takes priority over a timeout that expires in the
            // same cycle.
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            busy    <= 1'b0;
            state_r <= st_idle;
            if (rnw_r) begin
              rsp_data  <= reg_rdata;
              rsp_valid <= 1'b1;
            end else begin
              rsp_valid <= 1'b0;
            end
          end else if (wait_r == WAIT_LAST) begin
            // The access is abandoned. No response is produced, and the
            // event counter saturates.
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            busy    <= 1'b0;
            state_r <= st_idle;
            if (timeout_cnt != CNT_MAX) begin
              timeout_cnt <= timeout_cnt + CW'(1'b1);
            end else begin
              timeout_cnt <= timeout_cnt;
            end
          end else begin
            wait_r  <= wait_r + WW'(1'b1);
            busy    <= 1'b1;
            state_r <= st_access;
          end
        end

        default: begin
          // An unreachable encoding recovers to a safe idle with the
          // strobes dropped.
          reg_we  <= 1'b0;
          reg_re  <= 1'b0;
          busy    <= 1'b0;
          state_r <= st_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_cmd_dispatch.sv
// Directed self-checking bench for fifo_cmd_dispatch.
// A behavioural normal-mode FIFO feeds the block. A responder acks each
// strobe after a programmable number of cycles.

module tb_fifo_cmd_dispatch;

  localparam int TO = 8;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [56:0]   fifo_q = 57'h0;
  logic          fifo_rdempty;
  logic          fifo_rdreq;
  logic [23:0]   reg_addr;
  logic [31:0]   reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic          reg_ack;
  logic [31:0]   reg_rdata = 32'h1234_5678;
  logic [31:0]   rsp_data;
  logic          rsp_valid;
  logic [CW-1:0] timeout_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;

  fifo_cmd_dispatch #(.DW(57), .AW(24), .TIMEOUT(TO), .CW(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty), .fifo_rdreq(fifo_rdreq),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .timeout_cnt(timeout_cnt), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural FIFO: the data appears one cycle after rdreq.
  logic [56:0] mem [0:63];
  int wr = 0;
  int rd = 0;
  assign fifo_rdempty = (wr == rd);

  // Pop side of the FIFO model.
  always @(posedge clock) begin
    if (fifo_rdreq && (rd < wr)) begin
      fifo_q <= mem[rd % 64];
      rd     <= rd + 1;
    end
  end

  // Bus responder: acks when the strobe has been high for ack_lat cycles.
  int   ack_lat = 0;
  int   st_cnt = 0;
  logic ack_force = 1'b0;
  assign reg_ack = ack_force | ((reg_we | reg_re) && (st_cnt == ack_lat));

  // Count how long the current strobe has been high.
  always @(posedge clock) begin
    st_cnt <= (reg_we | reg_re) ? st_cnt + 1 : 0;
  end

  // Event monitor, sampled mid-cycle.
  int cyc = 0, n_rdreq = 0, n_we = 0, n_re = 0, n_rsp = 0, n_busy = 0;
  int n_both = 0, n_under = 0;
  int rdreq_cyc[$];

  // Accumulate per-cycle observations.
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (fifo_rdreq) begin
      n_rdreq <= n_rdreq + 1;
      rdreq_cyc.push_back(cyc);
    end
    if (reg_we) n_we <= n_we + 1;
    if (reg_re) n_re <= n_re + 1;
    if (rsp_valid) n_rsp <= n_rsp + 1;
    if (busy) n_busy <= n_busy + 1;
    if (reg_we && reg_re) n_both <= n_both + 1;
    if (fifo_rdreq && fifo_rdempty) n_under <= n_under + 1;
  end

  int s_rdreq, s_we, s_re, s_rsp, s_busy;

  task automatic snap();
    s_rdreq = n_rdreq; s_we = n_we; s_re = n_re; s_rsp = n_rsp; s_busy = n_busy;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input logic [56:0] w);
    mem[wr % 64] = w;
    wr = wr + 1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input int maxc);
    int k;
    k = 0;
    while (!(reg_we | reg_re) && (k < maxc)) begin
      tick(1);
      k++;
    end
    check("strobe_seen", {63'd0, reg_we | reg_re}, 64'd1);
  endtask

  initial begin
    // ---- Reset state
    tick(3);
    check("rst_rdreq", fifo_rdreq, 0);
    check("rst_we", reg_we, 0);
    check("rst_re", reg_re, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_tcnt", timeout_cnt, 0);
    check("rst_addr", reg_addr, 0);
    @(negedge clock);
    reset = 1'b0;
    tick(2);

    // ---- 1: a write, acked 2 cycles after reg_we rises
    enable = 1'b1;
    ack_lat = 2;
    snap();
    push({1'b0, 24'h000010, 32'hDEADBEEF});
    tick(12);
    check("t1_rdreq", n_rdreq - s_rdreq, 1);
    check("t1_we_cycles", n_we - s_we, 3);
    check("t1_re_cycles", n_re - s_re, 0);
    check("t1_rsp", n_rsp - s_rsp, 0);
    check("t1_busy_cycles", n_busy - s_busy, 5);
    check("t1_addr", reg_addr, 24'h000010);
    check("t1_wdata", reg_wdata, 32'hDEADBEEF);
    check("t1_busy_end", busy, 0);

    // ---- 2: a read with an immediate ack
    ack_lat = 0;
    reg_rdata = 32'h1234_5678;
    snap();
    push({1'b1, 24'h000004, 32'hCAFE0000});
    tick(10);
    check("t2_re_cycles", n_re - s_re, 1);
    check("t2_we_cycles", n_we - s_we, 0);
    check("t2_rsp_pulses", n_rsp - s_rsp, 1);
    check("t2_rsp_data", rsp_data, 32'h1234_5678);
    check("t2_addr", reg_addr, 24'h000004);

    // ---- 3: a read that is never acked times out, then a write completes
    ack_lat = 100;
    reg_rdata = 32'hBAD0BAD0;
    snap();
    push({1'b1, 24'h000008, 32'h0});
    tick(15);
    check("t3_re_cycles", n_re - s_re, TO);
    check("t3_rsp", n_rsp - s_rsp, 0);
    check("t3_tcnt", timeout_cnt, 1);
    check("t3_rsp_data_kept", rsp_data, 32'h1234_5678);
    ack_lat = 1;
    snap();
    push({1'b0, 24'h00000C, 32'h0BADF00D});
    tick(10);
    check("t3_next_we", n_we - s_we, 2);
    check("t3_next_addr", reg_addr, 24'h00000C);
    check("t3_tcnt_kept", timeout_cnt, 1);

    // ---- An ack outside ACCESS is ignored
    snap();
    ack_force = 1'b1;
    tick(1);
    ack_force = 1'b0;
    tick(2);
    check("stray_ack_rsp", n_rsp - s_rsp, 0);
    check("stray_ack_busy", busy, 0);
    check("stray_ack_tcnt", timeout_cnt, 1);

    // ---- 4: three queued words, each acked on the first ACCESS cycle
    ack_lat = 0;
    snap();
    push({1'b0, 24'h000100, 32'h11111111});
    push({1'b0, 24'h000101, 32'h22222222});
    push({1'b0, 24'h000102, 32'h33333333});
    tick(16);
    check("t4_rdreq", n_rdreq - s_rdreq, 3);
    check("t4_we_cycles", n_we - s_we, 3);
    check("t4_gap1", rdreq_cyc[rdreq_cyc.size()-2] - rdreq_cyc[rdreq_cyc.size()-3], 4);
    check("t4_gap2", rdreq_cyc[rdreq_cyc.size()-1] - rdreq_cyc[rdreq_cyc.size()-2], 4);
    check("t4_addr", reg_addr, 24'h000102);
    check("t4_wdata", reg_wdata, 32'h33333333);

    // ---- 5: enable low holds the block idle; dropping enable mid-access completes the access
    enable = 1'b0;
    snap();
    push({1'b0, 24'h000200, 32'h44444444});
    tick(10);
    check("t5_no_rdreq", n_rdreq - s_rdreq, 0);
    check("t5_idle", busy, 0);
    ack_lat = 3;
    snap();
    enable = 1'b1;
    wait_strobe(10);
    enable = 1'b0;
    push({1'b0, 24'h000300, 32'h55555555});
    tick(12);
    check("t5_we_cycles", n_we - s_we, 4);
    check("t5_rdreq", n_rdreq - s_rdreq, 1);
    check("t5_addr", reg_addr, 24'h000200);
    check("t5_held", busy, 0);

    // ---- 6: an asynchronous reset while reg_we is high
    ack_lat = 100;
    enable = 1'b1;
    wait_strobe(10);
    check("t6_we_before", reg_we, 1);
    check("t6_tcnt_before", timeout_cnt, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_we", reg_we, 0);
    check("t6_re", reg_re, 0);
    check("t6_busy", busy, 0);
    check("t6_rdreq", fifo_rdreq, 0);
    check("t6_tcnt", timeout_cnt, 0);
    check("t6_addr", reg_addr, 0);
    check("t6_wdata", reg_wdata, 0);
    check("t6_rsp_data", rsp_data, 0);
    @(negedge clock);
    reset = 1'b0;
    tick(2);
    ack_lat = 0;
    snap();
    push({1'b0, 24'h000400, 32'h55AA55AA});
    tick(8);
    check("t6_after_we", n_we - s_we, 1);
    check("t6_after_addr", reg_addr, 24'h000400);
    check("t6_after_wdata", reg_wdata, 32'h55AA55AA);
    check("t6_after_tcnt", timeout_cnt, 0);

    // ---- The timeout counter saturates at 2^CW-1
    ack_lat = 100;
    snap();
    for (int i = 0; i < 4; i++) push({1'b1, 24'h000500, 32'h0});
    tick(55);
    check("sat_rdreq", n_rdreq - s_rdreq, 4);
    check("sat_re_cycles", n_re - s_re, 4 * TO);
    check("sat_rsp", n_rsp - s_rsp, 0);
    check("sat_tcnt", timeout_cnt, 3);
    check("sat_idle", busy, 0);

    // ---- Whole-run invariants
    check("never_both_strobes", n_both, 0);
    check("no_rdreq_when_empty", n_under, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
